ram_burst_reader: RTL and testbench
===================================

RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is asynchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock shared with the 32x16K dual-port RAM.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port start, input, 1 bit: single-cycle request to begin a burst.
REQ-005 Port base_addr, input, 14 bits: first RAM word address; sampled with start.
REQ-006 Port length, input, 15 bits: word count, 0..16384; sampled with start.
REQ-007 Port busy, output, 1 bit: a burst is in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-009 Port ram_addr, output, 14 bits, registered: drives RAM port B address.
REQ-010 Port ram_we, output, 1 bit: drives RAM port B write enable; constant 0.
REQ-011 Port ram_din, output, 32 bits: drives RAM port B write data; constant 0.
REQ-012 Port ram_rdata, input, 32 bits: RAM port B read data; valid one clock after the address edge.
REQ-013 Port m_data, output, 32 bits: stream data.
REQ-014 Port m_valid, output, 1 bit: stream valid.
REQ-015 Port m_ready, input, 1 bit: stream ready from the downstream consumer.
REQ-016 Port m_last, output, 1 bit: marks the final beat of a burst.

Function
REQ-017 The FSM SHALL have three states:
- IDLE: not busy.
- READ: issuing reads.
- DRAIN: all reads issued, output FIFO not yet empty.
REQ-018 The FSM SHALL move IDLE->READ on start with length>0, capturing base_addr and length in the same edge; ram_addr SHALL equal base_addr in the following cycle.
REQ-019 The FSM SHALL pulse done in the cycle after start when start arrives with length==0; it SHALL stay in IDLE and emit no beats.
REQ-020 busy SHALL be high in READ and DRAIN and low in IDLE.
REQ-021 The block SHALL ignore start while busy=1.
REQ-022 A read SHALL be issued in a READ cycle when (FIFO occupancy + reads in flight) < 4.
- On issue, ram_addr SHALL advance by 1, modulo 16384 (0x3FFF wraps to 0x0000).
- On issue, the remaining-count SHALL decrement.
REQ-023 Read data SHALL be captured into a 4-entry output FIFO exactly 2 edges after the edge that presented its address, in issue order, with no loss and no duplication.
REQ-024 With m_ready held high, the first m_valid SHALL rise 2 edges after the start edge, and the block SHALL sustain one beat per cycle with no bubbles.
REQ-025 A beat SHALL transfer when m_valid & m_ready. m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 The FSM SHALL move READ->DRAIN on the edge that issues the final read.
REQ-027 m_last SHALL be 1 only on beat number length.
REQ-028 DRAIN SHALL move to IDLE on the edge of the m_last transfer; done SHALL pulse and busy SHALL fall in the following cycle.
REQ-029 length==16384 SHALL read every address exactly once, wrapping past 0x3FFF when base_addr!=0.

Reset
REQ-030 While rst_n=0, the block SHALL hold the following reset values:
- state IDLE
- busy=0, done=0, m_valid=0, m_last=0
- m_data=0, ram_addr=0
- FIFO empty, in-flight count 0, remaining-count 0
REQ-031 Reset asserted mid-burst SHALL abort the burst and discard buffered data; no done pulse SHALL be issued for the aborted burst.
REQ-032 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Verification
REQ-033 Basic burst: RAM preloaded mem[i]=i; start, base=0x0010, len=4, m_ready=1.
- Beats 0x10..0x13 on consecutive cycles; m_last on 0x13.
- done pulses exactly once.
REQ-034 Wrap: base=0x3FFE, len=4.
- Data from addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, in that order.
REQ-035 Backpressure: len=16; m_ready toggles with a random pattern, including 10 consecutive low cycles.
- All 16 words delivered in order, none lost or duplicated.
- m_data stable while stalled.
- FIFO never overflows.
REQ-036 Zero and ignored starts:
- len=0: done one cycle later, no m_valid.
- start pulsed while busy: no effect on the burst in progress.
REQ-037 Reset mid-burst: rst_n=0 after 3 of 8 beats.
- All outputs at reset values.
- A new burst of len=2 completes normally.
REQ-038 Full memory: len=16384, base=0x2000, m_ready=1.
- 16384 beats, each address exactly once.
- m_last only on the final beat.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Small first-word-fall-through FIFO used as the output buffer of the burst reader.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ram_burst_fifo #(
    parameter int W      = 33,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// Streams a burst of words from a synchronous-read RAM port onto a valid/ready stream.
// Latency: first beat valid 2 edges after the start edge; one beat per cycle thereafter.
// Backpressure: m_ready low fills the 4-entry FIFO, after which address issue stalls.
module ram_burst_reader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] base_addr,
    input  logic [14:0] length,
    output logic        busy,
    output logic        done,
    output logic [13:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_rdata,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [14:0] remaining;
    logic        rd_vld;
    logic        rd_last;
    logic        issue;
    logic        pop;
    logic [2:0]  fifo_cnt;
    logic [32:0] head_dat;

    assign ram_we  = 1'b0;
    assign ram_din = 32'd0;

    // A read is in flight for exactly one cycle, so FIFO space is reserved for it up front.
    assign issue = (state == READ) && (({1'b0, fifo_cnt} + {3'b000, rd_vld}) < 4'd4);

    assign m_valid = (fifo_cnt != 3'd0);
    assign m_data  = head_dat[31:0];
    assign m_last  = head_dat[32] & m_valid;
    assign pop     = m_valid & m_ready;

    ram_burst_fifo #(
        .W     (33),
        .DEPTH (4)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_vld),
        .push_dat ({rd_last, ram_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            remaining <= '0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_vld  <= issue;
            rd_last <= issue && (remaining == 15'd1);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != 15'd0) begin
                            state     <= READ;
                            ram_addr  <= base_addr;
                            remaining <= length;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        ram_addr  <= ram_addr + 14'd1;
                        remaining <= remaining - 15'd1;
                        if (remaining == 15'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a synchronous-read RAM model holding mem[i]=i.
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] length;
    logic        busy;
    logic        done;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_rdata;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [32:0] beats[$];
    int          beat_cyc[$];
    logic [31:0] mem [16384];

    ram_burst_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_rdata (ram_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = i;
    end

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: collects accepted beats and verifies data holds during stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(m_valid), 64'd1);
                check("stall_hold_data", 64'(m_data), 64'(prev_data));
                check("stall_hold_last", 64'(m_last), 64'(prev_last));
                stall_cnt++;
            end
            if (m_valid && m_ready) begin
                beats.push_back({m_last, m_data});
                beat_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic clear_log();
        beats.delete();
        beat_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [13:0] b, input logic [14:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        length = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic check_burst(input string tag, input logic [13:0] b, input int len);
        int bad_d;
        int bad_l;
        logic [13:0] a;
        bad_d = 0;
        bad_l = 0;
        check({tag, "_count"}, 64'(beats.size()), 64'(len));
        for (int i = 0; i < beats.size() && i < len; i++) begin
            a = b + 14'(i);
            if (beats[i][31:0] !== {18'd0, a}) bad_d++;
            if (beats[i][32] !== (i == len - 1)) bad_l++;
        end
        check({tag, "_data_bad"}, 64'(bad_d), 64'd0);
        check({tag, "_last_bad"}, 64'(bad_l), 64'd0);
    endtask

    task automatic check_gaps(input string tag);
        int bad;
        bad = 0;
        for (int i = 1; i < beat_cyc.size(); i++) begin
            if (beat_cyc[i] != beat_cyc[i-1] + 1) bad++;
        end
        check({tag, "_gaps"}, 64'(bad), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_last"}, 64'(m_last), 64'd0);
        check({tag, "_m_data"}, 64'(m_data), 64'd0);
        check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        check({tag, "_ram_we"}, 64'(ram_we), 64'd0);
        check({tag, "_ram_din"}, 64'(ram_din), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // Basic burst, with start raised together with reset release
        @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        start = 1'b1;
        base_addr = 14'h0010;
        length = 15'd4;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("basic_addr_e0", 64'(ram_addr), 64'h10);
        check("basic_busy_e0", 64'(busy), 64'd1);
        check("basic_valid_e0", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        check("basic_valid_e1", 64'(m_valid), 64'd0);
        @(posedge clk);
        #1;
        check("basic_valid_e2", 64'(m_valid), 64'd1);
        check("basic_data_e2", 64'(m_data), 64'h10);
        check("basic_last_e2", 64'(m_last), 64'd0);
        wait_done(100, "basic");
        repeat (3) @(posedge clk);
        check_burst("basic", 14'h0010, 4);
        check_gaps("basic");
        check("basic_done_once", 64'(done_cnt), 64'd1);
        check("basic_done_timing", 64'(done_cyc), 64'(beat_cyc[beat_cyc.size()-1] + 1));

        // Address wrap
        clear_log();
        do_start(14'h3FFE, 15'd4);
        wait_done(100, "wrap");
        repeat (2) @(posedge clk);
        check_burst("wrap", 14'h3FFE, 4);

        // Backpressure with a 10-cycle stall
        clear_log();
        stall_cnt = 0;
        do_start(14'h0100, 15'd16);
        got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(posedge clk);
            #1;
            m_ready = (n >= 4 && n < 14) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            got = done;
            n++;
        end
        m_ready = 1'b1;
        check("bp_done_seen", 64'(got), 64'd1);
        repeat (2) @(posedge clk);
        check_burst("bp", 14'h0100, 16);
        check("bp_stalled", 64'(stall_cnt >= 10), 64'd1);

        // Zero-length start
        clear_log();
        do_start(14'h0040, 15'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("zero_done_drop", 64'(done), 64'd0);
        repeat (4) @(posedge clk);
        check("zero_beats", 64'(beats.size()), 64'd0);
        check("zero_done_once", 64'(done_cnt), 64'd1);

        // Start pulsed while busy must be ignored
        clear_log();
        do_start(14'h0200, 15'd8);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 14'h3000;
        length = 15'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, "ign");
        repeat (6) @(posedge clk);
        #1;
        check_burst("ign", 14'h0200, 8);
        check("ign_done_once", 64'(done_cnt), 64'd1);
        check("ign_idle", 64'(busy), 64'd0);

        // Reset after 3 of 8 beats
        clear_log();
        do_start(14'h0400, 15'd8);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        check("midrst_beats", 64'(beats.size()), 64'd3);
        repeat (3) @(posedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        do_start(14'h0500, 15'd2);
        wait_done(100, "post_rst");
        repeat (2) @(posedge clk);
        check_burst("post_rst", 14'h0500, 2);
        check("post_rst_done_once", 64'(done_cnt), 64'd1);

        // Whole memory from 0x2000
        clear_log();
        do_start(14'h2000, 15'd16384);
        wait_done(17000, "full");
        repeat (2) @(posedge clk);
        check_burst("full", 14'h2000, 16384);
        check_gaps("full");
        check("full_done_once", 64'(done_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
